// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//
// Main controller for the multicycle RV32I core. It steps each instruction
// through fetch, decode, execute, memory and writeback, and drives every
// enable and mux select of the shared datapath: the ALU, the unified
// instruction/data memory port, the register file and the immediate extender.
//
// Memory handshake:
//   The controller holds a memory request (fetch, load or store) for as long
//   as mem_ready is low. The request completes in the cycle where mem_ready is
//   high: the state then advances at the next edge. Any write enable that
//   depends on completion (ir_write/pc_write in FETCH) follows mem_ready in
//   the same cycle. Each cycle with mem_ready low costs one extra cycle.
//
// Ports:
//   clk          rising-edge system clock
//   rst          synchronous active-high reset; forces every output to 0
//   op           instr[6:0] from the instruction register
//   funct3       instr[14:12]
//   funct7_5     instr[30]
//   zero         ALU zero flag (branch compare)
//   mem_ready    memory completes the current access this cycle
//   pc_write     PC load enable
//   adr_src      memory address select: 0 PC, 1 result
//   mem_write    memory write request
//   ir_write     instruction register / old-PC load enable
//   result_src   00 alu_out reg, 01 read data, 10 ALU result
//   alu_src_a    00 PC, 01 old PC, 10 rd1
//   alu_src_b    00 rd2, 01 imm_ext, 10 constant 4
//   alu_control  000 add, 001 sub, 010 and, 011 or, 101 slt
//   imm_src      00 I, 01 B, 10 S, 11 J
//   reg_write    register file write enable
//   illegal      high while parked in TRAP
//   state_o      current state encoding, for debug
// ---------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int OP_WIDTH    = 7,
  parameter int STATE_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [OP_WIDTH-1:0]    op,
  input  logic [2:0]             funct3,
  input  logic                   funct7_5,
  input  logic                   zero,
  input  logic                   mem_ready,
  output logic                   pc_write,
  output logic                   adr_src,
  output logic                   mem_write,
  output logic                   ir_write,
  output logic [1:0]             result_src,
  output logic [1:0]             alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [2:0]             alu_control,
  output logic [1:0]             imm_src,
  output logic                   reg_write,
  output logic                   illegal,
  output logic [STATE_WIDTH-1:0] state_o
);

  // -------------------------------------------------------------------------
  // State encoding (12..15 are unused and fall back to FETCH)
  // -------------------------------------------------------------------------
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  // Opcodes
  localparam logic [OP_WIDTH-1:0] OP_LOAD   = OP_WIDTH'(7'b0000011);
  localparam logic [OP_WIDTH-1:0] OP_STORE  = OP_WIDTH'(7'b0100011);
  localparam logic [OP_WIDTH-1:0] OP_RTYPE  = OP_WIDTH'(7'b0110011);
  localparam logic [OP_WIDTH-1:0] OP_ITYPE  = OP_WIDTH'(7'b0010011);
  localparam logic [OP_WIDTH-1:0] OP_BRANCH = OP_WIDTH'(7'b1100011);
  localparam logic [OP_WIDTH-1:0] OP_JAL    = OP_WIDTH'(7'b1101111);

  // ALU operations
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t state;

  // -------------------------------------------------------------------------
  // Instruction classification
  // -------------------------------------------------------------------------
  logic is_load;
  logic is_store;
  logic is_rtype;
  logic is_itype;
  logic is_branch;
  logic is_jal;
  logic mem_f3_ok;   // only word accesses are implemented
  logic alu_f3_ok;   // add/sub, slt, or, and
  logic br_f3_ok;    // beq, bne

  assign is_load   = (op == OP_LOAD);
  assign is_store  = (op == OP_STORE);
  assign is_rtype  = (op == OP_RTYPE);
  assign is_itype  = (op == OP_ITYPE);
  assign is_branch = (op == OP_BRANCH);
  assign is_jal    = (op == OP_JAL);

  assign mem_f3_ok = (funct3 == 3'b010);
  assign alu_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                     (funct3 == 3'b110) || (funct3 == 3'b111);
  assign br_f3_ok  = (funct3 == 3'b000) || (funct3 == 3'b001);

  // -------------------------------------------------------------------------
  // ALU operation for EXECR/EXECI. Subtract is only an R-type encoding;
  // an addi with imm[10] set (instr[30]) must still add.
  // -------------------------------------------------------------------------
  logic [2:0] alu_exec_op;

  always_comb begin
    alu_exec_op = ALU_ADD;
    case (funct3)
      3'b000:  alu_exec_op = (state == S_EXECR && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_exec_op = ALU_AND;
      3'b110:  alu_exec_op = ALU_OR;
      3'b010:  alu_exec_op = ALU_SLT;
      default: alu_exec_op = ALU_ADD;
    endcase
  end

  // -------------------------------------------------------------------------
  // Branch decision: beq takes on zero, bne on not-zero
  // -------------------------------------------------------------------------
  logic branch_taken;

  assign branch_taken = (funct3 == 3'b001) ? ~zero : zero;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ready) state <= S_DECODE;
        end
        S_DECODE: begin
          if ((is_load || is_store) && mem_f3_ok) state <= S_MEMADR;
          else if (is_rtype && alu_f3_ok)         state <= S_EXECR;
          else if (is_itype && alu_f3_ok)         state <= S_EXECI;
          else if (is_branch && br_f3_ok)         state <= S_BEQ;
          else if (is_jal)                        state <= S_JAL;
          else                                    state <= S_TRAP;
        end
        S_MEMADR: begin
          // The instruction register is stable here, so op still selects.
          if (is_load)       state <= S_MEMREAD;
          else if (is_store) state <= S_MEMWRITE;
          else               state <= S_TRAP;
        end
        S_MEMREAD: begin
          if (mem_ready) state <= S_MEMWB;
        end
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: begin
          if (mem_ready) state <= S_FETCH;
        end
        S_EXECR:    state <= S_ALUWB;
        S_EXECI:    state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BEQ:      state <= S_FETCH;
        // jal: PC gets the target now, rd gets old PC + 4 in ALUWB
        S_JAL:      state <= S_ALUWB;
        S_TRAP:     state <= S_TRAP;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output decode (Moore on state, with the branch pc_write, the FETCH
  // completion enables, imm_src and alu_control looking at the instruction
  // fields and handshake). Reset overrides everything to zero.
  // -------------------------------------------------------------------------
  always_comb begin
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    imm_src     = 2'b00;
    reg_write   = 1'b0;
    illegal     = 1'b0;

    case (state)
      S_FETCH: begin
        // PC + 4 is computed while the instruction is read; both land
        // only once the memory completes.
        adr_src    = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        // Precompute old PC + imm for a possible branch.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        result_src = 2'b00;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        result_src = 2'b00;
        mem_write  = 1'b1;
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b00;
        alu_control = alu_exec_op;
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_exec_op;
      end
      S_ALUWB: begin
        result_src = 2'b00;
        reg_write  = 1'b1;
      end
      S_BEQ: begin
        // alu_out still holds the target from DECODE.
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b00;
        alu_control = ALU_SUB;
        result_src  = 2'b00;
        pc_write    = branch_taken;
      end
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        result_src = 2'b00;
        pc_write   = 1'b1;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: begin
      end
    endcase

    // Immediate format depends only on the opcode.
    case (op)
      OP_LOAD, OP_ITYPE: imm_src = 2'b00;
      OP_BRANCH:         imm_src = 2'b01;
      OP_STORE:          imm_src = 2'b10;
      OP_JAL:            imm_src = 2'b11;
      default:           imm_src = 2'b00;
    endcase

    if (rst) begin
      pc_write    = 1'b0;
      adr_src     = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      result_src  = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      alu_control = ALU_ADD;
      imm_src     = 2'b00;
      reg_write   = 1'b0;
      illegal     = 1'b0;
    end
  end

  assign state_o = rst ? '0 : STATE_WIDTH'(state);

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main controller for the multicycle RV32I core.
- Sequences the shared ALU, the unified instruction/data memory port, the register file and the immediate extender across fetch, decode, execute, memory and writeback states.
- Sources all datapath enables and mux selects, including imm_src for the extender.
- Stalls on a memory ready handshake.
- Parks in a trap state on any unsupported instruction.

Parameters:
- OP_WIDTH, 7, opcode field width.
- STATE_WIDTH, 4, width of the state encoding and of the state_o debug port.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- op  in  7  instr[6:0] from the instruction register.
- funct3  in  3  instr[14:12].
- funct7_5  in  1  instr[30].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current read/write this cycle.
- pc_write  out  1  PC register load enable.
- adr_src  out  1  memory address: 0 PC, 1 result.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register / old-PC load enable.
- result_src  out  2  00 alu_out reg, 01 read data, 10 ALU result.
- alu_src_a  out  2  00 PC, 01 old PC, 10 rd1.
- alu_src_b  out  2  00 rd2, 01 imm_ext, 10 constant 4.
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- imm_src  out  2  00 I, 01 B, 10 S, 11 J.
- reg_write  out  1  register file write enable.
- illegal  out  1  high in TRAP.
- state_o  out  STATE_WIDTH  current state, for debug.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - rst is synchronous and active-high.
  - On rst, state becomes FETCH (0) at the next edge.
  - While rst is high, all outputs are 0 (enables low, selects 00, alu_control add).
  - A reset in any state, including mid-wait or TRAP, aborts the operation. No write enable may be asserted in the reset cycle.
- Output structure:
  - Outputs are Moore, decoded from the state.
  - Exceptions: imm_src, alu_control and the branch pc_write are also decoded from op, funct3 and zero.
- imm_src is decoded from op in every state:
  - 0000011 and 0010011 -> 00
  - 1100011 -> 01
  - 0100011 -> 10
  - 1101111 -> 11
  - anything else -> 00
- States (encoding in brackets) and outputs; unlisted enables are 0:
  - FETCH(0): adr_src 0, alu_src_a 00, alu_src_b 10, add, result_src 10. ir_write and pc_write equal mem_ready. Stay while mem_ready is 0. -> DECODE when mem_ready is 1.
  - DECODE(1): alu_src_a 01, alu_src_b 01, add (precomputes branch target).
    - lw (funct3 010) or sw (funct3 010) -> MEMADR.
    - R-type -> EXECR. I-ALU -> EXECI.
    - Branch with funct3 000/001 -> BEQ.
    - jal -> JAL.
    - Otherwise, including unsupported funct3, -> TRAP.
  - MEMADR(2): alu_src_a 10, alu_src_b 01, add. -> MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD(3): adr_src 1, result_src 00. Wait for mem_ready, then -> MEMWB.
  - MEMWB(4): result_src 01, reg_write 1. -> FETCH.
  - MEMWRITE(5): adr_src 1, result_src 00, mem_write 1, held until mem_ready. -> FETCH on mem_ready.
  - EXECR(6): alu_src_a 10, alu_src_b 00. -> ALUWB.
  - EXECI(7): alu_src_a 10, alu_src_b 01. -> ALUWB.
  - ALUWB(8): result_src 00, reg_write 1. -> FETCH.
  - BEQ(9): alu_src_a 10, alu_src_b 00, sub, result_src 00. pc_write = zero for funct3 000 (beq), ~zero for funct3 001 (bne). -> FETCH.
  - JAL(10): alu_src_a 01, alu_src_b 10, add, result_src 00, pc_write 1. -> ALUWB (writes PC+4 to rd).
  - TRAP(11): illegal 1, all enables 0. Exits only via rst.
  - Encodings 12–15 -> FETCH next cycle, outputs as TRAP minus illegal.
- ALU decode in EXECR/EXECI:
  - funct3 000: add; sub only when R-type and funct7_5 is 1.
  - funct3 111: and. 110: or. 010: slt.
  - Other funct3 already trapped in DECODE.
- Cycles per instruction with mem_ready always high: lw 5, sw 4, R/I 4, branch 3, jal 4.
- Each cycle that mem_ready is low adds exactly one cycle in FETCH, MEMREAD or MEMWRITE.

Test Plan:
- rst high 2 cycles with mem_ready=1 -> all outputs 0; first cycle after release: state_o=0, ir_write=1, pc_write=1.
- add x3,x1,x2 (op 0110011, f3 000, f7_5 0) -> states 0,1,6,8,0; alu_control 000 in EXECR; reg_write 1 only in ALUWB. With f7_5=1 -> alu_control 001.
- lw (0000011, f3 010) with mem_ready low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles, then MEMWB with result_src 01, reg_write 1; imm_src 00 throughout.
- sw (0100011, f3 010) -> imm_src 10; mem_write high every MEMWRITE cycle until mem_ready; never reg_write.
- beq with zero=1 then zero=0, and bne with both -> pc_write 1,0,0,1 respectively in BEQ; imm_src 01.
- Opcode 0110111, then reset asserted in TRAP -> illegal=1 from the cycle after DECODE; after rst, state_o=0 and illegal=0.
